// File: rtl/mem_wr_arbiter_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mem_wr_arbiter_pkg
// Desc     : Shared types and memory-map constants for the BRAM write arbiter.
// Revision : 1.0 - initial release
//==============================================================================
package mem_wr_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE      = 1'b0,
        ARB_DMA_BURST = 1'b1
    } arb_state_e;

    localparam int unsigned c_STARVE_LIMIT = 8;

    // Memory-map select bits, also used by the store formatter and UART decode
    localparam int unsigned c_DMEM_BIT = 28;
    localparam int unsigned c_IMEM_BIT = 29;

endpackage : mem_wr_arbiter_pkg
`default_nettype wire

// File: rtl/mem_wr_arbiter_starve_counter.sv
`default_nettype none
//==============================================================================
// Module   : arb_starve_counter
// Desc     : 8-bit saturating wait counter with synchronous clear and increment.
// Revision : 1.0 - initial release
//==============================================================================
module arb_starve_counter #(
    parameter logic [7:0] LIMIT = 8'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] cnt
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clr) begin
            r_cnt <= 8'd0;
        end else if (inc && (r_cnt != LIMIT)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign cnt = r_cnt;

endmodule : arb_starve_counter
`default_nettype wire

// File: rtl/mem_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : mem_wr_arbiter
// Desc     : CPU/DMA write arbiter for the shared dmem/imem BRAM byte-write ports.
// Revision : 1.0 - initial release
//==============================================================================
module mem_wr_arbiter
    import mem_wr_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = c_STARVE_LIMIT,
    parameter int unsigned DMEM_BIT     = c_DMEM_BIT,
    parameter int unsigned IMEM_BIT     = c_IMEM_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_data,
    input  logic [3:0]  cpu_wea,
    input  logic        cpu_imem_ok,
    output logic        cpu_stall,
    input  logic        dma_valid,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_data,
    input  logic [3:0]  dma_wea,
    input  logic        dma_lock,
    output logic        dma_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  dmem_wea,
    output logic [3:0]  imem_wea
);

    localparam logic [7:0] c_LIMIT8 = 8'(STARVE_LIMIT);

    arb_state_e  r_state;
    logic        w_cpu_req;
    logic        w_dma_req;
    logic        w_force_dma;
    logic        w_grant_cpu;
    logic        w_grant_dma;
    logic        w_cnt_inc;
    logic        w_cnt_clr;
    logic [7:0]  w_starve_cnt;
    logic [31:0] w_win_addr;
    logic [31:0] w_win_data;
    logic [3:0]  w_win_wea;
    logic [3:0]  w_dmem_wea_d;
    logic [3:0]  w_imem_wea_d;

    assign w_cpu_req   = |cpu_wea;
    assign w_dma_req   = dma_valid && (|dma_wea);
    assign w_force_dma = (w_starve_cnt == c_LIMIT8);

    // A held burst excludes the CPU even while the DMA engine pauses
    always_comb begin
        w_grant_dma = 1'b0;
        w_grant_cpu = 1'b0;
        if (r_state == ARB_DMA_BURST) begin
            w_grant_dma = w_dma_req;
        end else begin
            w_grant_dma = w_dma_req && (w_force_dma || !w_cpu_req);
            w_grant_cpu = w_cpu_req && !w_grant_dma;
        end
    end

    assign cpu_stall = w_cpu_req && !w_grant_cpu;
    assign dma_ready = w_grant_dma;

    assign w_cnt_inc = w_dma_req && !w_grant_dma;
    assign w_cnt_clr = !w_dma_req || w_grant_dma;

    arb_starve_counter #(
        .LIMIT (c_LIMIT8)
    ) u_starve_counter (
        .clk (clk),
        .rst (rst),
        .clr (w_cnt_clr),
        .inc (w_cnt_inc),
        .cnt (w_starve_cnt)
    );

    always_comb begin
        w_win_addr   = cpu_addr;
        w_win_data   = cpu_data;
        w_win_wea    = cpu_wea;
        w_dmem_wea_d = 4'b0000;
        w_imem_wea_d = 4'b0000;
        if (w_grant_dma) begin
            w_win_addr = dma_addr;
            w_win_data = dma_data;
            w_win_wea  = dma_wea;
        end
        if (w_grant_dma || w_grant_cpu) begin
            if (w_win_addr[DMEM_BIT]) begin
                w_dmem_wea_d = w_win_wea;
            end
            // CPU imem writes additionally require the PC-region qualifier
            if (w_win_addr[IMEM_BIT] && (w_grant_dma || cpu_imem_ok)) begin
                w_imem_wea_d = w_win_wea;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ARB_IDLE;
            mem_addr <= 32'd0;
            mem_din  <= 32'd0;
            dmem_wea <= 4'b0000;
            imem_wea <= 4'b0000;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_dma && dma_lock) begin
                        r_state <= ARB_DMA_BURST;
                    end
                end
                ARB_DMA_BURST: begin
                    if (w_grant_dma && !dma_lock) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase

            if (w_grant_dma || w_grant_cpu) begin
                mem_addr <= w_win_addr;
                mem_din  <= w_win_data;
            end
            dmem_wea <= w_dmem_wea_d;
            imem_wea <= w_imem_wea_d;
        end
    end

endmodule : mem_wr_arbiter
`default_nettype wire

// File: tb/tb_mem_wr_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : tb_mem_wr_arbiter
// Desc     : Directed scoreboard bench for mem_wr_arbiter.
// Revision : 1.0 - initial release
//==============================================================================
module tb_mem_wr_arbiter;
    import mem_wr_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_data = '0;
    logic [3:0]  cpu_wea = '0;
    logic        cpu_imem_ok = 1'b0;
    logic        cpu_stall;
    logic        dma_valid = 1'b0;
    logic [31:0] dma_addr = '0;
    logic [31:0] dma_data = '0;
    logic [3:0]  dma_wea = '0;
    logic        dma_lock = 1'b0;
    logic        dma_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  dmem_wea;
    logic [3:0]  imem_wea;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  dw;
        logic [3:0]  iw;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_din   = '0;

    always #5 clk = ~clk;

    mem_wr_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_addr    (cpu_addr),
        .cpu_data    (cpu_data),
        .cpu_wea     (cpu_wea),
        .cpu_imem_ok (cpu_imem_ok),
        .cpu_stall   (cpu_stall),
        .dma_valid   (dma_valid),
        .dma_addr    (dma_addr),
        .dma_data    (dma_data),
        .dma_wea     (dma_wea),
        .dma_lock    (dma_lock),
        .dma_ready   (dma_ready),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .dmem_wea    (dmem_wea),
        .imem_wea    (imem_wea)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // One cycle: drive, check grant, predict registered write, check it next edge
    task automatic step(input string tag,
                        input logic [3:0] cw, input logic [31:0] ca, input logic [31:0] cd,
                        input logic ok,
                        input logic dv, input logic [31:0] da, input logic [31:0] dd,
                        input logic [3:0] dw, input logic dl,
                        input logic exp_stall, input logic exp_ready);
        exp_t e;
        exp_t got;
        @(negedge clk);
        cpu_wea = cw; cpu_addr = ca; cpu_data = cd; cpu_imem_ok = ok;
        dma_valid = dv; dma_addr = da; dma_data = dd; dma_wea = dw; dma_lock = dl;
        #1;
        chk({tag, ".stall"}, 32'(cpu_stall), 32'(exp_stall));
        chk({tag, ".ready"}, 32'(dma_ready), 32'(exp_ready));
        e.addr = m_addr; e.din = m_din; e.dw = 4'b0; e.iw = 4'b0;
        if (exp_ready) begin
            e.addr = da; e.din = dd;
            e.dw = da[28] ? dw : 4'b0;
            e.iw = da[29] ? dw : 4'b0;
        end else if ((|cw) && !exp_stall) begin
            e.addr = ca; e.din = cd;
            e.dw = ca[28] ? cw : 4'b0;
            e.iw = (ca[29] && ok) ? cw : 4'b0;
        end
        m_addr = e.addr; m_din = e.din;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = q.pop_front();
            chk({tag, ".mem_addr"}, mem_addr, got.addr);
            chk({tag, ".mem_din"},  mem_din,  got.din);
            chk({tag, ".dmem_wea"}, 32'(dmem_wea), 32'(got.dw));
            chk({tag, ".imem_wea"}, 32'(imem_wea), 32'(got.iw));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst.dmem_wea", 32'(dmem_wea), 32'd0);
        chk("rst.imem_wea", 32'(imem_wea), 32'd0);
        chk("rst.mem_addr", mem_addr, 32'd0);
        chk("rst.mem_din",  mem_din,  32'd0);
        chk("rst.state", 32'(dut.r_state), 32'(ARB_IDLE));
        chk("rst.cnt", 32'(dut.u_starve_counter.r_cnt), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++)
            step("idle", 4'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);

        // CPU-only stores
        step("cpu_dmem", 4'b0011, 32'h1000_0004, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        step("cpu_imem_blocked", 4'b0011, 32'h2000_0000, 32'h0000_BEEF, 1'b0, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        step("cpu_imem_ok", 4'b1100, 32'h2000_0008, 32'hCAFE_0000, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        step("cpu_both", 4'b1111, 32'h3000_0010, 32'h1234_5678, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        step("cpu_unmapped", 4'b0001, 32'h0000_0040, 32'h0000_00AA, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);
        step("dma_only_dmem", 4'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1000_0200, 32'h5555_AAAA, 4'b0110, 1'b0, 1'b0, 1'b1);
        step("dma_no_wea", 4'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1000_0204, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Contention: CPU wins until the counter reaches the limit
        for (int i = 0; i < 8; i++)
            step("cont_cpu", 4'b1111, 32'h1000_0008, 32'h1111_2222, 1'b1, 1'b1, 32'h1000_0100, 32'hD0D0_0001, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("cont.cnt_at_limit", 32'(dut.u_starve_counter.r_cnt), 32'd8);
        step("cont_forced", 4'b1111, 32'h1000_0008, 32'h1111_2222, 1'b1, 1'b1, 32'h1000_0100, 32'hD0D0_0001, 4'b1111, 1'b0, 1'b1, 1'b1);
        chk("cont.cnt_cleared", 32'(dut.u_starve_counter.r_cnt), 32'd0);
        step("cont_cpu_again", 4'b1111, 32'h1000_000C, 32'h3333_4444, 1'b1, 1'b1, 32'h1000_0104, 32'hD0D0_0002, 4'b1111, 1'b0, 1'b0, 1'b0);

        // Withdrawn DMA request forfeits accumulated wait
        step("drop_wait", 4'b1111, 32'h1000_0010, 32'h0, 1'b1, 1'b1, 32'h1000_0104, 32'hD0D0_0002, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("drop.cnt_before", 32'(dut.u_starve_counter.r_cnt), 32'd2);
        step("drop_cpu_only", 4'b1111, 32'h1000_0014, 32'h0, 1'b1, 1'b0, 32'h1000_0104, 32'hD0D0_0002, 4'b1111, 1'b0, 1'b0, 1'b0);
        chk("drop.cnt_cleared", 32'(dut.u_starve_counter.r_cnt), 32'd0);

        // Locked DMA burst of 4 beats into imem
        step("burst_b0", 4'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000_0000, 32'hB000_0000, 4'b1111, 1'b1, 1'b0, 1'b1);
        chk("burst.state_locked", 32'(dut.r_state), 32'(ARB_DMA_BURST));
        step("burst_b1", 4'b1111, 32'h1000_0020, 32'h0, 1'b1, 1'b1, 32'h2000_0004, 32'hB000_0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        step("burst_b2", 4'b1111, 32'h1000_0020, 32'h0, 1'b1, 1'b1, 32'h2000_0008, 32'hB000_0002, 4'b1111, 1'b1, 1'b1, 1'b1);
        step("burst_b3", 4'b1111, 32'h1000_0020, 32'h0, 1'b1, 1'b1, 32'h2000_000C, 32'hB000_0003, 4'b1111, 1'b0, 1'b1, 1'b1);
        chk("burst.state_idle", 32'(dut.r_state), 32'(ARB_IDLE));
        step("burst_after_cpu", 4'b1111, 32'h1000_0020, 32'h7777_8888, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);

        // Burst paused by dma_valid low keeps its grant
        step("pause_b0", 4'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000_0010, 32'hC000_0000, 4'b1111, 1'b1, 1'b0, 1'b1);
        step("pause_gap0", 4'b0011, 32'h1000_0030, 32'h0, 1'b1, 1'b0, 32'h2000_0014, 32'hC000_0001, 4'b1111, 1'b1, 1'b1, 1'b0);
        step("pause_gap1", 4'b0011, 32'h1000_0030, 32'h0, 1'b1, 1'b0, 32'h2000_0014, 32'hC000_0001, 4'b1111, 1'b1, 1'b1, 1'b0);
        chk("pause.state_held", 32'(dut.r_state), 32'(ARB_DMA_BURST));
        step("pause_b1", 4'b0011, 32'h1000_0030, 32'h0, 1'b1, 1'b1, 32'h2000_0014, 32'hC000_0001, 4'b1111, 1'b0, 1'b1, 1'b1);
        chk("pause.state_idle", 32'(dut.r_state), 32'(ARB_IDLE));

        // Asynchronous reset in the middle of a burst
        step("rstb_b0", 4'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h2000_0020, 32'hE000_0000, 4'b1111, 1'b1, 1'b0, 1'b1);
        step("rstb_b1", 4'b1111, 32'h1000_0040, 32'h0, 1'b1, 1'b1, 32'h2000_0024, 32'hE000_0001, 4'b1111, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstb.imem_wea", 32'(imem_wea), 32'd0);
        chk("rstb.dmem_wea", 32'(dmem_wea), 32'd0);
        chk("rstb.mem_addr", mem_addr, 32'd0);
        chk("rstb.state", 32'(dut.r_state), 32'(ARB_IDLE));
        m_addr = '0;
        m_din  = '0;
        @(negedge clk);
        rst = 1'b0;
        step("rstb_cpu", 4'b1111, 32'h1000_0044, 32'h9999_0000, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mem_wr_arbiter
`default_nettype wire

// File: doc/mem_wr_arbiter.md
# mem_wr_arbiter

Two-requester write arbiter for the shared BRAM byte-write ports (data memory and instruction memory). It sits between the store lane/byte-enable formatter and the memories. It merges CPU stores with writes from the DMA/boot-loader engine, stalls the CPU when it loses arbitration, and bounds DMA starvation with a wait counter. All memory-side outputs are registered, so a granted write reaches the BRAM port one cycle after grant.

## Interface
- `STARVE_LIMIT`, 8: consecutive cycles a waiting DMA request may lose before it is forced through (range 1–255).
- `DMEM_BIT`, 28: address bit selecting data memory.
- `IMEM_BIT`, 29: address bit selecting instruction memory.

- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_addr` in 32: CPU store address.
- `cpu_data` in 32: CPU store data, already lane-shifted.
- `cpu_wea` in 4: CPU byte enables. Nonzero means a request.
- `cpu_imem_ok` in 1: imem write permitted (PC[30] qualifier).
- `cpu_stall` out 1: CPU store not accepted this cycle; hold the pipeline.
- `dma_valid` in 1: DMA write request.
- `dma_addr` in 32: DMA word address.
- `dma_data` in 32: DMA data.
- `dma_wea` in 4: DMA byte enables.
- `dma_lock` in 1: keep the grant after this beat (burst).
- `dma_ready` out 1: DMA beat accepted this cycle.
- `mem_addr` out 32: registered write address.
- `mem_din` out 32: registered write data.
- `dmem_wea` out 4: registered dmem byte enables.
- `imem_wea` out 4: registered imem byte enables.

## Operation
- `cpu_req = |cpu_wea`. `dma_req = dma_valid && |dma_wea`.
- States:
  - IDLE: no lock held. Fixed priority to the CPU, except DMA wins when `starve_cnt == STARVE_LIMIT`.
  - DMA_BURST: entered when a granted DMA beat has `dma_lock=1`. DMA has exclusive grant and the CPU is stalled on any `cpu_req`. Exit to IDLE on the first accepted beat with `dma_lock=0`.
  - In DMA_BURST with `dma_valid=0`: stay in DMA_BURST, grant nobody, and stall the CPU.
- Grant, combinational within the cycle:
  - `cpu_stall = cpu_req && !grant_cpu`.
  - `dma_ready = grant_dma`.
- `starve_cnt`, 8 bits:
  - Increments when `dma_req` is present and not granted.
  - Clears on a DMA grant or when `dma_req` is deasserted.
  - Saturates at `STARVE_LIMIT`.
- Routing of the granted request:
  - `mem_addr`/`mem_din` register the winner's address and data.
  - `dmem_wea` = winner's wea when `addr[DMEM_BIT]`, else 0.
  - `imem_wea` = winner's wea when `addr[IMEM_BIT]` and (DMA winner, or CPU winner with `cpu_imem_ok`), else 0.
  - Both enables may be nonzero for an address with both bits set.
- No grant: `dmem_wea`/`imem_wea` register 0. `mem_addr`/`mem_din` hold their previous values.
- A CPU request with an address outside both memories is still granted. It consumes the slot but produces zero enables.

## Timing
- Reset values: `dmem_wea=0`, `imem_wea=0`, `mem_addr=0`, `mem_din=0`, state IDLE, `starve_cnt=0`. Combinationally, `cpu_stall` and `dma_ready` follow the inputs; with IDLE state and no requests both are 0.
- Latency: grant in cycle N gives BRAM enables at cycle N+1. Maximum throughput is one write per cycle.
- Simultaneous requests in IDLE with `starve_cnt<STARVE_LIMIT`: CPU granted, DMA waits, counter increments.
- Forced DMA grant lasts exactly one beat unless `dma_lock=1`. The counter then clears.
- `rst` asserted mid-burst: immediate return to IDLE, enables drop to 0 asynchronously, and any in-flight registered write is discarded.
- `dma_valid` dropping while waiting: the counter clears and no starvation credit is carried over.

## Structure
- Shared package/header holds:
  - state encodings `ARB_IDLE=1'b0`, `ARB_DMA_BURST=1'b1`;
  - `STARVE_LIMIT` default;
  - the memory-map bit positions shared with the store formatter and the UART decode.
- One sub-module is natural: `arb_starve_counter`, a saturating counter with clear and increment inputs. The FSM and output registers stay in the top module.

## Test plan
- Reset release with idle inputs: all outputs 0 for 3 cycles.
- CPU-only stream:
  - `cpu_addr=0x1000_0004`, `cpu_wea=0011`, `cpu_data=0x0000_BEEF` → next cycle `dmem_wea=0011`, `mem_din=0x0000_BEEF`, `imem_wea=0`, `cpu_stall=0`.
  - Same write with `cpu_addr=0x2000_0000`, `cpu_imem_ok=0` → `imem_wea=0`.
- Contention with `STARVE_LIMIT=8`: CPU stores and DMA valid every cycle → CPU granted 8 cycles, then in cycle 9 `dma_ready=1`, `cpu_stall=1`, and `starve_cnt` returns to 0.
- DMA burst of 4 beats to `0x2000_0000..0x2000_000C` with lock high for the first 3 beats:
  - `imem_wea=1111` on 4 consecutive cycles;
  - `cpu_stall=1` throughout;
  - IDLE after beat 4.
- Burst stalled: `dma_valid` drops for 2 cycles inside a burst → no enables and CPU stays stalled; the burst resumes without re-arbitration.
- Assert `rst` for 1 cycle mid-burst → enables 0 immediately, state IDLE, and a CPU store on the next cycle is granted.
